// File: rtl/bm_mem_arb_pkg.sv
// Shared types for the bitmatrix SRAM arbiter.
// Owner tags follow each SRAM command through the read-return pipe.
package bm_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_ENG,
    OWN_HRD,
    OWN_HWR
  } owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/bm_mem_arb_tag_pipe.sv
// Owner-tag shift register aligned with SRAM read latency.
// Last stage lines up with the cycle mem_rdata is valid.
module bm_mem_arb_tag_pipe
  import bm_mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= OWN_NONE;
      end
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/bm_mem_arb.sv
// Single-port bitmatrix SRAM arbiter: engine reads first,
// host read/write round-robin with a starvation override.
module bm_mem_arb
  import bm_mem_arb_pkg::*;
#(
  parameter int BM_MEM_ADDR_W = 8,
  parameter int BM_COL_W      = 64,
  parameter int MEM_RD_LAT    = 1,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eng_busy,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic                     bm_mem_bm_cntl_rd_gnt,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val,
  input  logic                     host_wr_req,
  input  logic [BM_MEM_ADDR_W-1:0] host_wr_addr,
  input  logic [BM_COL_W-1:0]      host_wr_data,
  output logic                     host_wr_gnt,
  input  logic                     host_rd_req,
  input  logic [BM_MEM_ADDR_W-1:0] host_rd_addr,
  output logic                     host_rd_gnt,
  output logic [BM_COL_W-1:0]      host_rd_data,
  output logic                     host_rd_data_val,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [BM_MEM_ADDR_W-1:0] mem_addr,
  output logic [BM_COL_W-1:0]      mem_wdata,
  input  logic [BM_COL_W-1:0]      mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM =
    STARVE_CNT_W'(STARVE_MAX);

  logic                     hw_el;
  logic                     hr_el;
  logic                     host_pend;
  logic                     force_host;
  logic                     pick_wr;
  logic                     gnt_e;
  logic                     gnt_hr;
  logic                     gnt_hw;
  logic                     host_gnt;
  logic                     rr_wr;
  logic [STARVE_CNT_W-1:0]  starve_cnt;
  logic [STARVE_CNT_W-1:0]  starve_nxt;
  owner_t                   win_tag;
  owner_t                   ret_tag;
  logic [BM_MEM_ADDR_W-1:0] cmd_addr;
  logic                     eng_val;
  logic                     hrd_val;
  logic [BM_COL_W-1:0]      eng_data_q;
  logic [BM_COL_W-1:0]      hrd_data_q;

  // eng_busy masks host writes out of both arbitration and starvation
  always_comb begin
    hw_el      = host_wr_req & ~eng_busy;
    hr_el      = host_rd_req;
    host_pend  = hw_el | hr_el;
    force_host = host_pend && (starve_cnt == STARVE_LIM);
    pick_wr    = hw_el & (~hr_el | rr_wr);
    gnt_e      = bm_cntl_bm_mem_rd_rq & ~force_host;
    gnt_hr     = ~gnt_e & hr_el & ~pick_wr;
    gnt_hw     = ~gnt_e & pick_wr;
    host_gnt   = gnt_hr | gnt_hw;
  end

  always_comb begin
    win_tag  = OWN_NONE;
    cmd_addr = '0;
    unique case (1'b1)
      gnt_e: begin
        win_tag  = OWN_ENG;
        cmd_addr = bm_cntl_bm_mem_rd_addr;
      end
      gnt_hr: begin
        win_tag  = OWN_HRD;
        cmd_addr = host_rd_addr;
      end
      gnt_hw: begin
        win_tag  = OWN_HWR;
        cmd_addr = host_wr_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_nxt = '0;
    if (!host_gnt && host_pend) begin
      starve_nxt = (starve_cnt == STARVE_LIM) ?
        starve_cnt : starve_cnt + 1'b1;
    end
  end

  assign bm_mem_bm_cntl_rd_gnt = gnt_e;
  assign host_rd_gnt           = gnt_hr;
  assign host_wr_gnt           = gnt_hw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      rr_wr      <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (gnt_hr) rr_wr <= 1'b1;
      if (gnt_hw) rr_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= gnt_e | host_gnt;
      mem_we <= gnt_hw;
      if (gnt_e | host_gnt) mem_addr <= cmd_addr;
      if (gnt_hw) mem_wdata <= host_wr_data;
    end
  end

  bm_mem_arb_tag_pipe #(
    .DEPTH (MEM_RD_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (win_tag),
    .tag_out (ret_tag)
  );

  assign eng_val = (ret_tag == OWN_ENG);
  assign hrd_val = (ret_tag == OWN_HRD);

  // Data buses show live rdata on their own return cycle, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_data_q <= '0;
      hrd_data_q <= '0;
    end else begin
      if (eng_val) eng_data_q <= mem_rdata;
      if (hrd_val) hrd_data_q <= mem_rdata;
    end
  end

  assign bm_mem_bm_cntl_rd_data_val = eng_val;
  assign host_rd_data_val           = hrd_val;
  assign bm_mem_bm_cntl_rd_data = eng_val ? mem_rdata : eng_data_q;
  assign host_rd_data           = hrd_val ? mem_rdata : hrd_data_q;

endmodule

// File: tb/tb_bm_mem_arb.sv
// Directed bench for bm_mem_arb with a 1-cycle SRAM model.
// Inputs change 1ns after posedge; checks run 1ns later.
module tb_bm_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        eng_busy;
  logic        e_rq;
  logic [7:0]  e_addr;
  logic        e_gnt;
  logic [63:0] e_data;
  logic        e_val;
  logic        hw_req;
  logic [7:0]  hw_addr;
  logic [63:0] hw_data;
  logic        hw_gnt;
  logic        hr_req;
  logic [7:0]  hr_addr;
  logic        hr_gnt;
  logic [63:0] hr_data;
  logic        hr_val;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bm_mem_arb #(
    .BM_MEM_ADDR_W (8),
    .BM_COL_W      (64),
    .MEM_RD_LAT    (1),
    .STARVE_MAX    (4)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .eng_busy                   (eng_busy),
    .bm_cntl_bm_mem_rd_rq       (e_rq),
    .bm_cntl_bm_mem_rd_addr     (e_addr),
    .bm_mem_bm_cntl_rd_gnt      (e_gnt),
    .bm_mem_bm_cntl_rd_data     (e_data),
    .bm_mem_bm_cntl_rd_data_val (e_val),
    .host_wr_req                (hw_req),
    .host_wr_addr               (hw_addr),
    .host_wr_data               (hw_data),
    .host_wr_gnt                (hw_gnt),
    .host_rd_req                (hr_req),
    .host_rd_addr               (hr_addr),
    .host_rd_gnt                (hr_gnt),
    .host_rd_data               (hr_data),
    .host_rd_data_val           (hr_val),
    .mem_en                     (mem_en),
    .mem_we                     (mem_we),
    .mem_addr                   (mem_addr),
    .mem_wdata                  (mem_wdata),
    .mem_rdata                  (mem_rdata)
  );

  function automatic logic [63:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {24'hC0FFEE, b, 24'h5A5A5A, ~b};
  endfunction

  logic [63:0] sram [256];

  // SRAM model: preloads during reset, 1-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= pat(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    eng_busy = 1'b0;
    e_rq     = 1'b0;
    e_addr   = '0;
    hw_req   = 1'b0;
    hw_addr  = '0;
    hw_data  = '0;
    hr_req   = 1'b0;
    hr_addr  = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_in();
    do_reset();
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_e_val", 64'(e_val), 0);
    chk("rst_e_data", e_data, 0);
    chk("rst_hr_data", hr_data, 0);
    step();

    // engine-only stream, addresses 0..7
    for (int k = 0; k < 10; k++) begin
      e_rq   = (k < 8);
      e_addr = 8'(k);
      #1;
      chk($sformatf("eng_gnt%0d", k), 64'(e_gnt), 64'(k < 8));
      chk($sformatf("eng_val%0d", k), 64'(e_val),
          64'(k >= 2));
      if (k >= 2) chk($sformatf("eng_dat%0d", k), e_data, pat(k - 2));
      step();
    end
    idle_in();
    repeat (2) step();

    // starvation override for host read
    for (int k = 0; k < 13; k++) begin
      e_rq    = 1'b1;
      e_addr  = 8'(8'h20 + k);
      hr_req  = (k >= 5 && k <= 9);
      hr_addr = 8'h30;
      #1;
      chk($sformatf("stv_egnt%0d", k), 64'(e_gnt), 64'(k != 9));
      chk($sformatf("stv_hgnt%0d", k), 64'(hr_gnt), 64'(k == 9));
      chk($sformatf("stv_hval%0d", k), 64'(hr_val), 64'(k == 11));
      chk($sformatf("stv_eval%0d", k), 64'(e_val),
          64'(k >= 2 && k != 11));
      if (k == 11) chk("stv_hdat", hr_data, pat(8'h30));
      if (k == 12) chk("stv_edat", e_data, pat(8'h20 + 10));
      step();
    end
    idle_in();
    repeat (2) step();

    // round robin from reset: RD, WR, RD, WR
    do_reset();
    for (int k = 0; k < 4; k++) begin
      hr_req  = 1'b1;
      hr_addr = 8'h50;
      hw_req  = 1'b1;
      hw_addr = 8'h40;
      hw_data = 64'h1111_2222_3333_4444;
      #1;
      chk($sformatf("rr_rd%0d", k), 64'(hr_gnt), 64'(k % 2 == 0));
      chk($sformatf("rr_wr%0d", k), 64'(hw_gnt), 64'(k % 2 == 1));
      step();
    end
    idle_in();
    repeat (3) step();

    // write lockout while engine busy
    for (int k = 0; k < 22; k++) begin
      eng_busy = (k < 20);
      hw_req   = (k <= 20);
      hw_addr  = 8'h60;
      hw_data  = 64'hDEAD_BEEF_0000_0060;
      #1;
      if (k < 20) begin
        chk($sformatf("lk_gnt%0d", k), 64'(hw_gnt), 0);
        chk($sformatf("lk_stv%0d", k), 64'(dut.starve_cnt), 0);
      end
      if (k == 10) chk("lk_memen", 64'(mem_en), 0);
      if (k == 20) chk("lk_gnt_rel", 64'(hw_gnt), 1);
      if (k == 21) begin
        chk("lk_we", 64'(mem_we), 1);
        chk("lk_en", 64'(mem_en), 1);
        chk("lk_addr", 64'(mem_addr), 64'h60);
        chk("lk_wdat", mem_wdata, 64'hDEAD_BEEF_0000_0060);
      end
      step();
    end
    idle_in();
    repeat (2) step();

    // write then engine read of same address
    hw_req  = 1'b1;
    hw_addr = 8'h12;
    hw_data = 64'hA5A5_A5A5_A5A5_A5A5;
    #1;
    chk("coh_wgnt", 64'(hw_gnt), 1);
    step();
    hw_req = 1'b0;
    e_rq   = 1'b1;
    e_addr = 8'h12;
    #1;
    chk("coh_egnt", 64'(e_gnt), 1);
    step();
    e_rq = 1'b0;
    #1;
    chk("coh_val_early", 64'(e_val), 0);
    step();
    chk("coh_val", 64'(e_val), 1);
    chk("coh_dat", e_data, 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    chk("coh_val_end", 64'(e_val), 0);
    chk("coh_hold", e_data, 64'hA5A5_A5A5_A5A5_A5A5);
    repeat (2) step();

    // reset while an engine read is in flight
    e_rq   = 1'b1;
    e_addr = 8'h05;
    #1;
    chk("rmf_gnt", 64'(e_gnt), 1);
    step();
    e_rq = 1'b0;
    rst  = 1'b1;
    #1;
    chk("rmf_en", 64'(mem_en), 0);
    chk("rmf_addr", 64'(mem_addr), 0);
    chk("rmf_eval", 64'(e_val), 0);
    chk("rmf_edat", e_data, 0);
    chk("rmf_hdat", hr_data, 0);
    step();
    chk("rmf_eval2", 64'(e_val), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rmf_post%0d", k), 64'(e_val | hr_val), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
